issue_sequencer: RTL and testbench

Front-end sequencer that feeds Identify. Accepts 32-bit instruction words from fetch over a valid/ready handshake and buffers them in a small FIFO. Assembles complete instructions (plain 32-bit, or prefixed 64-bit per ISA 3.1) and presents one per cycle on Identify's i_en/i_instr with a hold-until-accepted handshake. Supports a synchronous flush on branch redirect.

---
 rtl/issue_sequencer_pkg.sv | 17 +
 rtl/issue_sequencer_fifo.sv | 53 +++++
 rtl/issue_sequencer.sv | 99 +++++++++
 tb/tb_issue_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_sequencer_pkg.sv
// Shared definitions for the issue sequencer: prefix opcode, prefix detection
// and the output-register state encoding.
package issue_sequencer_pkg;

  localparam logic [5:0] PRIMARY_OPCODE_PREFIX = 6'd1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_t;

  // Bit 31 of the fetched word is ISA bit 0, so the primary opcode lives in [31:26].
  function automatic logic is_prefix(input logic [31:0] word);
    return word[31:26] == PRIMARY_OPCODE_PREFIX;
  endfunction

endpackage

// File: rtl/issue_sequencer_fifo.sv
// Word FIFO for the issue sequencer: exposes the two oldest words so a
// prefix+suffix pair can be popped together.
module instr_fifo
  import issue_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [31:0]              wdata,
  input  logic                     pop1,
  input  logic                     pop2,
  input  logic                     flush,
  output logic [31:0]              head,
  output logic [31:0]              head_next,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    pop_amt;

  assign pop_amt   = pop2 ? 2'd2 : (pop1 ? 2'd1 : 2'd0);
  assign head      = mem[rd_ptr];
  assign head_next = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Occupancy is kept separately from the pointers so full and empty never alias.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_ptr + AW'(pop_amt);
      count  <= count + CW'(push) - CW'(pop_amt);
    end
  end

endmodule

// File: rtl/issue_sequencer.sv
// Front-end sequencer: buffers fetched words and presents complete plain or
// prefixed instructions to Identify with a hold-until-accepted handshake.
module issue_sequencer
  import issue_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_fetch_valid,
  input  logic [31:0]             i_fetch_word,
  output logic                    o_fetch_ready,
  input  logic                    i_flush,
  output logic                    o_id_en,
  output logic [63:0]             o_id_instr,
  output logic                    o_id_prefixed,
  input  logic                    i_id_ready,
  output logic [CNT_W-1:0]        o_issued_cnt,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  out_state_t  state;
  out_state_t  state_next;
  logic [31:0] head;
  logic [31:0] head_next;
  logic        head_is_prefix;
  logic        complete;
  logic        can_load;
  logic        load;
  logic        push;
  logic        accept;

  assign o_fetch_ready  = (o_count != CW'(DEPTH));
  assign push           = i_fetch_valid && o_fetch_ready && !i_flush;
  assign head_is_prefix = is_prefix(head);
  assign complete       = (o_count >= CW'(1) && !head_is_prefix) ||
                          (o_count >= CW'(2) && head_is_prefix);
  assign can_load       = !o_id_en || i_id_ready;
  assign load           = can_load && complete && !i_flush;
  assign accept         = o_id_en && i_id_ready;

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .wdata     (i_fetch_word),
    .pop1      (load && !head_is_prefix),
    .pop2      (load && head_is_prefix),
    .flush     (i_flush),
    .head      (head),
    .head_next (head_next),
    .count     (o_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = OUT_EMPTY;
    end else if (can_load) begin
      state_next = load ? OUT_VALID : OUT_EMPTY;
    end
  end

  always_comb begin
    o_id_en = (state == OUT_VALID);
  end

  // Payload keeps its last value when nothing loads, including after a flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_id_instr    <= '0;
      o_id_prefixed <= 1'b0;
    end else if (load) begin
      o_id_instr    <= head_is_prefix ? {head, head_next} : {32'b0, head};
      o_id_prefixed <= head_is_prefix;
    end
  end

  // Acceptances still count in a flush cycle; the counter wraps naturally.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_issued_cnt <= '0;
    end else if (accept) begin
      o_issued_cnt <= o_issued_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_issue_sequencer.sv
// Self-checking bench for issue_sequencer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_issue_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_word;
  logic        fetch_ready;
  logic        flush;
  logic        id_en;
  logic [63:0] id_instr;
  logic        id_prefixed;
  logic        id_ready;
  logic [CNT_W-1:0] issued_cnt;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [31:0] m_q[$];
  bit          m_en;
  logic [63:0] m_instr;
  bit          m_pref;
  int          m_cnt;

  issue_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_fetch_valid (fetch_valid),
    .i_fetch_word  (fetch_word),
    .o_fetch_ready (fetch_ready),
    .i_flush       (flush),
    .o_id_en       (id_en),
    .o_id_instr    (id_instr),
    .o_id_prefixed (id_prefixed),
    .i_id_ready    (id_ready),
    .o_issued_cnt  (issued_cnt),
    .o_count       (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit pfx(input logic [31:0] w);
    return (w >> 26) == 32'd1;
  endfunction

  // Apply one edge of the specification rules to the model.
  task automatic model_edge(input bit r, input bit v, input logic [31:0] w,
                            input bit f, input bit rdy);
    int sz;
    bit can_push;
    logic [31:0] w0;
    logic [31:0] w1;
    if (r) begin
      m_q.delete();
      m_en = 0;
      m_instr = '0;
      m_pref = 0;
      m_cnt = 0;
    end else begin
      sz = m_q.size();
      can_push = v && (sz != DEPTH);
      if (m_en && rdy) m_cnt = (m_cnt + 1) % (1 << CNT_W);
      if (f) begin
        m_q.delete();
        m_en = 0;
      end else begin
        if (!m_en || rdy) begin
          if (sz >= 1 && !pfx(m_q[0])) begin
            w0 = m_q.pop_front();
            m_instr = {32'b0, w0};
            m_pref = 0;
            m_en = 1;
          end else if (sz >= 2 && pfx(m_q[0])) begin
            w0 = m_q.pop_front();
            w1 = m_q.pop_front();
            m_instr = {w0, w1};
            m_pref = 1;
            m_en = 1;
          end else begin
            m_en = 0;
          end
        end
        if (can_push) m_q.push_back(w);
      end
    end
  endtask

  // Drive one cycle of inputs, clock it, update the model, then settle.
  task automatic tick(input bit r, input bit v, input logic [31:0] w,
                      input bit f, input bit rdy);
    rst = r;
    fetch_valid = v;
    fetch_word = w;
    flush = f;
    id_ready = rdy;
    @(posedge clk);
    model_edge(r, v, w, f, rdy);
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 32'h0, 0, 0);
    tick(1, 0, 32'h0, 0, 0);
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_en got=%0b exp=0", id_en); end
    total++; if (id_instr !== 64'h0) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=0", id_instr); end
    total++; if (id_prefixed !== 1'b0) begin bad++; $display("[TB] FAIL reset_pref got=%0b exp=0", id_prefixed); end
    total++; if (issued_cnt !== '0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", issued_cnt); end
    total++; if (count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready got=%0b exp=1", fetch_ready); end
  endtask

  task automatic test_single_plain();
    tick(0, 1, 32'hDFD4C012, 0, 1);
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL plain_lat_en got=%0b exp=0", id_en); end
    total++; if (count !== 3'd1) begin bad++; $display("[TB] FAIL plain_count got=%0d exp=1", count); end
    tick(0, 0, 32'h0, 0, 1);
    total++; if (id_en !== 1'b1) begin bad++; $display("[TB] FAIL plain_en got=%0b exp=1", id_en); end
    total++; if (id_instr !== 64'h00000000_DFD4C012) begin bad++; $display("[TB] FAIL plain_instr got=%h exp=00000000dfd4c012", id_instr); end
    total++; if (id_prefixed !== 1'b0) begin bad++; $display("[TB] FAIL plain_pref got=%0b exp=0", id_prefixed); end
    tick(0, 0, 32'h0, 0, 1);
    total++; if (issued_cnt !== 4'd1) begin bad++; $display("[TB] FAIL plain_cnt got=%0d exp=1", issued_cnt); end
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL plain_drain got=%0b exp=0", id_en); end
  endtask

  task automatic test_prefixed_pair();
    int issues;
    issues = 0;
    tick(0, 1, 32'h04000000, 0, 1);
    tick(0, 1, 32'h38600001, 0, 1);
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL pair_early_en got=%0b exp=0", id_en); end
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 32'h0, 0, 1);
      if (id_en === 1'b1) begin
        issues++;
        total++; if (id_instr !== 64'h04000000_38600001) begin bad++; $display("[TB] FAIL pair_instr got=%h exp=0400000038600001", id_instr); end
        total++; if (id_prefixed !== 1'b1) begin bad++; $display("[TB] FAIL pair_pref got=%0b exp=1", id_prefixed); end
      end
    end
    total++; if (issues != 1) begin bad++; $display("[TB] FAIL pair_issues got=%0d exp=1", issues); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL pair_count got=%0d exp=0", count); end
    total++; if (issued_cnt !== 4'(m_cnt)) begin bad++; $display("[TB] FAIL pair_cnt got=%0d exp=%0d", issued_cnt, m_cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = 32'h1000_0000 + 32'(i) * 32'h11;
    for (int i = 0; i < 6; i++) tick(0, 1, w[i], 0, 0);
    total++; if (count !== 3'd4) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=4", count); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready got=%0b exp=0", fetch_ready); end
    total++; if (id_en !== 1'b1) begin bad++; $display("[TB] FAIL bp_en got=%0b exp=1", id_en); end
    tick(0, 0, 32'h0, 0, 0);
    total++; if (id_instr !== {32'b0, w[0]}) begin bad++; $display("[TB] FAIL bp_stable got=%h exp=%h", id_instr, {32'b0, w[0]}); end
    for (int k = 1; k < 5; k++) begin
      tick(0, 0, 32'h0, 0, 1);
      total++; if (id_en !== 1'b1 || id_instr !== {32'b0, w[k]}) begin bad++; $display("[TB] FAIL bp_order k=%0d got=%0b/%h exp=1/%h", k, id_en, id_instr, {32'b0, w[k]}); end
    end
    tick(0, 0, 32'h0, 0, 1);
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0b exp=0", id_en); end
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL bp_empty got=%0d exp=0", count); end
  endtask

  task automatic test_split_prefix();
    tick(0, 1, 32'h04000000, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 32'h0, 0, 1);
      total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL split_wait i=%0d got=%0b exp=0", i, id_en); end
    end
    tick(0, 1, 32'h38600001, 0, 1);
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL split_same got=%0b exp=0", id_en); end
    tick(0, 0, 32'h0, 0, 1);
    total++; if (id_en !== 1'b1 || id_prefixed !== 1'b1) begin bad++; $display("[TB] FAIL split_issue got=%0b/%0b exp=1/1", id_en, id_prefixed); end
    total++; if (id_instr !== 64'h04000000_38600001) begin bad++; $display("[TB] FAIL split_instr got=%h exp=0400000038600001", id_instr); end
    tick(0, 0, 32'h0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) tick(0, 1, 32'h2000_0000 + 32'(i), 0, 0);
    total++; if (count !== 3'd3 || id_en !== 1'b1) begin bad++; $display("[TB] FAIL flush_pre got=%0d/%0b exp=3/1", count, id_en); end
    tick(0, 1, 32'hBAD0_0BAD, 1, 0);
    total++; if (count !== 3'd0) begin bad++; $display("[TB] FAIL flush_count got=%0d exp=0", count); end
    total++; if (id_en !== 1'b0) begin bad++; $display("[TB] FAIL flush_en got=%0b exp=0", id_en); end
    tick(0, 1, 32'h3000_0042, 0, 1);
    tick(0, 0, 32'h0, 0, 1);
    total++; if (id_en !== 1'b1 || id_instr !== 64'h00000000_30000042) begin bad++; $display("[TB] FAIL flush_after got=%0b/%h exp=1/0000000030000042", id_en, id_instr); end
    tick(0, 0, 32'h0, 0, 1);
    total++; if (id_en !== 1'b0 || count !== 3'd0) begin bad++; $display("[TB] FAIL flush_absent got=%0b/%0d exp=0/0", id_en, count); end
  endtask

  task automatic test_wrap_reset();
    tick(1, 0, 32'h0, 0, 0);
    for (int i = 0; i < 18; i++) tick(0, 1, 32'h0800_0000 + 32'(i), 0, 1);
    tick(0, 0, 32'h0, 0, 1);
    total++; if (issued_cnt !== 4'd1) begin bad++; $display("[TB] FAIL wrap_cnt got=%0d exp=1", issued_cnt); end
    total++; if (id_en !== 1'b1) begin bad++; $display("[TB] FAIL wrap_en got=%0b exp=1", id_en); end
    tick(1, 1, 32'h0, 1, 1);
    total++; if (id_en !== 1'b0 || id_instr !== 64'h0 || id_prefixed !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out got=%0b/%h/%0b exp=0/0/0", id_en, id_instr, id_prefixed); end
    total++; if (issued_cnt !== '0 || count !== '0) begin bad++; $display("[TB] FAIL midrst_cnt got=%0d/%0d exp=0/0", issued_cnt, count); end
  endtask

  task automatic test_random();
    bit r, v, f, rdy;
    logic [31:0] w;
    tick(1, 0, 32'h0, 0, 0);
    for (int cyc = 0; cyc < 400; cyc++) begin
      r   = ($urandom_range(0, 99) < 1);
      v   = ($urandom_range(0, 99) < 70);
      f   = ($urandom_range(0, 99) < 5);
      rdy = ($urandom_range(0, 99) < 60);
      w   = $urandom;
      if ($urandom_range(0, 99) < 30) w = {6'd1, w[25:0]};
      tick(r, v, w, f, rdy);
      total++; if (id_en !== m_en) begin bad++; $display("[TB] FAIL rand_en cyc=%0d got=%0b exp=%0b", cyc, id_en, m_en); end
      total++; if (id_instr !== m_instr) begin bad++; $display("[TB] FAIL rand_instr cyc=%0d got=%h exp=%h", cyc, id_instr, m_instr); end
      total++; if (id_prefixed !== m_pref) begin bad++; $display("[TB] FAIL rand_pref cyc=%0d got=%0b exp=%0b", cyc, id_prefixed, m_pref); end
      total++; if (issued_cnt !== 4'(m_cnt)) begin bad++; $display("[TB] FAIL rand_cnt cyc=%0d got=%0d exp=%0d", cyc, issued_cnt, m_cnt); end
      total++; if (count !== 3'(m_q.size())) begin bad++; $display("[TB] FAIL rand_count cyc=%0d got=%0d exp=%0d", cyc, count, m_q.size()); end
      total++; if (fetch_ready !== (m_q.size() != DEPTH)) begin bad++; $display("[TB] FAIL rand_ready cyc=%0d got=%0b exp=%0b", cyc, fetch_ready, m_q.size() != DEPTH); end
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_valid = 1'b0;
    fetch_word = '0;
    flush = 1'b0;
    id_ready = 1'b0;
    m_en = 0;
    m_instr = '0;
    m_pref = 0;
    m_cnt = 0;
    test_reset();
    test_single_plain();
    test_prefixed_pair();
    test_backpressure();
    test_split_prefix();
    test_flush();
    test_wrap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
